fft_addr_gen: RTL

- Control and address generator for the in-place radix-2 DIT FFT core. It sits directly upstream of the twiddle ROM stage.
- On start, it walks all R stages × N/2 butterflies of an N-point transform. Each cycle it issues:
  - the twiddle exponent to the twiddle ROM;
  - the two data-RAM addresses of the butterfly operand pair to the butterfly/RAM stage.
- Addresses are delayed internally by the ROM read latency so they arrive aligned with the twiddle values.

---
 rtl/fft_pkg.sv | 45 ++++
 rtl/fft_delay_line.sv | 56 +++++
 rtl/fft_addr_gen.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, FSM encoding and butterfly address math for the FFT address generator
package fft_pkg;

    localparam int FFT_N    = 32;
    localparam int FFT_R    = 5;
    localparam int FFT_HALF = FFT_N / 2;
    localparam int FFT_EW   = FFT_R - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_GAP,
        ST_FLUSH,
        ST_DONE
    } fft_state_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] expo;
    } bfly_t;

    // Operand pair and twiddle exponent of butterfly j in stage s of a 2^r-point DIT FFT.
    // a inserts a zero at bit s of j, b is its partner, and the exponent keeps
    // the low s bits of j scaled into the N/2-entry twiddle table.
    function automatic bfly_t fft_bfly(input logic [31:0] r, input logic [31:0] s,
                                       input logic [31:0] j);
        logic [31:0] lo;
        logic [31:0] hi;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        bfly_t       f;
        lo     = j & ((32'd1 << s) - 32'd1);
        hi     = (j >> s) << (s + 32'd1);
        a      = hi | lo;
        b      = a | (32'd1 << s);
        e      = lo << (r - 32'd1 - s);
        f.a    = a[15:0];
        f.b    = b[15:0];
        f.expo = e[15:0];
        return f;
    endfunction

endpackage

// File: rtl/fft_delay_line.sv
// rtl/fft_delay_line.sv - valid-qualified shift register that aligns butterfly addresses with the twiddle ROM output
module fft_delay_line #(
    parameter int W     = 8,
    parameter int DEPTH = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic clk_rst_unused;
            assign clk_rst_unused = i_clk ^ i_rst_n;
            assign o_valid        = i_valid;
            assign o_data         = i_data;
        end else begin : g_pipe
            logic [DEPTH-1:0] vld_q;
            logic [DEPTH-1:0] vld_d;
            logic [W-1:0]     dat_q [DEPTH];
            logic [W-1:0]     dat_d [DEPTH];

            // valid always shifts; a data stage only loads when valid data arrives, so idle cycles hold the last butterfly
            always_comb begin
                vld_d    = vld_q << 1;
                vld_d[0] = i_valid;
                dat_d[0] = i_valid ? i_data : dat_q[0];
                for (int k = 1; k < DEPTH; k++) begin
                    dat_d[k] = vld_q[k-1] ? dat_q[k-1] : dat_q[k];
                end
            end

            // stage registers, cleared at once on reset so outputs drop before the next edge
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    vld_q <= '0;
                    for (int k = 0; k < DEPTH; k++) begin
                        dat_q[k] <= '0;
                    end
                end else begin
                    vld_q <= vld_d;
                    for (int k = 0; k < DEPTH; k++) begin
                        dat_q[k] <= dat_d[k];
                    end
                end
            end

            assign o_valid = vld_q[DEPTH-1];
            assign o_data  = dat_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/fft_addr_gen.sv
// rtl/fft_addr_gen.sv - stage/butterfly sequencer issuing twiddle exponents and aligned in-place RAM addresses
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int N         = FFT_N,
    parameter int R         = FFT_R,
    parameter int TW_LAT    = 1,
    parameter int STAGE_GAP = 2,
    parameter int SW        = 3
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_done,
    output logic [R-2:0]  o_twiddle_exponent,
    output logic          o_tw_valid,
    output logic [R-1:0]  o_addr_a,
    output logic [R-1:0]  o_addr_b,
    output logic [SW-1:0] o_stage,
    output logic          o_valid
);

    localparam int             HALF       = N / 2;
    localparam int             DW         = SW + 2 * R;
    localparam logic [R-2:0]   J_LAST     = (R-1)'(HALF - 1);
    localparam logic [SW-1:0]  S_LAST     = SW'(R - 1);
    localparam logic [15:0]    GAP_LAST   = 16'(STAGE_GAP - 1);
    localparam logic [15:0]    FLUSH_LAST = 16'(TW_LAT - 1);

    fft_state_t    state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [R-2:0]  j_q, j_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [R-2:0]  exp_q, exp_d;
    logic [R-1:0]  a_q, a_d;
    logic [R-1:0]  b_q, b_d;
    logic [SW-1:0] st_q, st_d;
    logic          tw_valid_q, tw_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    bfly_t         bf;
    logic          bf_unused;
    logic [DW-1:0] dl_data;

    assign bf        = fft_bfly(32'(R), 32'(s_q), 32'(j_q));
    assign bf_unused = ^{bf.a[15:R], bf.b[15:R], bf.expo[15:R-1]};

    // sequencer: walks stages and butterflies, registers one issue per RUN cycle
    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        j_d        = j_q;
        cnt_d      = cnt_q;
        exp_d      = exp_q;
        a_d        = a_q;
        b_d        = b_q;
        st_d       = st_q;
        tw_valid_d = 1'b0;
        busy_d     = (state_q != ST_IDLE);
        done_d     = (state_q == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                // busy_q is still high in the cycle after DONE, which keeps a late start from retriggering
                if (i_start && !busy_q) begin
                    state_d = ST_RUN;
                    s_d     = '0;
                    j_d     = '0;
                end
            end
            ST_RUN: begin
                tw_valid_d = 1'b1;
                exp_d      = bf.expo[R-2:0];
                a_d        = bf.a[R-1:0];
                b_d        = bf.b[R-1:0];
                st_d       = s_q;
                j_d        = j_q + 1'b1;
                cnt_d      = '0;
                if (j_q == J_LAST) begin
                    j_d = '0;
                    if (s_q == S_LAST) begin
                        state_d = (TW_LAT > 0) ? ST_FLUSH : ST_DONE;
                    end else if (STAGE_GAP > 0) begin
                        state_d = ST_GAP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                // drain the butterfly pipeline before the next stage reads what this one wrote
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_RUN;
                    s_d     = s_q + 1'b1;
                end
            end
            ST_FLUSH: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == FLUSH_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state, counters and issue registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            s_q        <= '0;
            j_q        <= '0;
            cnt_q      <= '0;
            exp_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            st_q       <= '0;
            tw_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            j_q        <= j_d;
            cnt_q      <= cnt_d;
            exp_q      <= exp_d;
            a_q        <= a_d;
            b_q        <= b_d;
            st_q       <= st_d;
            tw_valid_q <= tw_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    fft_delay_line #(
        .W     (DW),
        .DEPTH (TW_LAT)
    ) u_delay (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (tw_valid_q),
        .i_data  ({st_q, a_q, b_q}),
        .o_valid (o_valid),
        .o_data  (dl_data)
    );

    assign o_stage            = dl_data[DW-1 -: SW];
    assign o_addr_a           = dl_data[2*R-1 -: R];
    assign o_addr_b           = dl_data[R-1:0];
    assign o_twiddle_exponent = exp_q;
    assign o_tw_valid         = tw_valid_q;
    assign o_busy             = busy_q;
    assign o_done             = done_q;

endmodule
